paralelo_serie_param: RTL and testbench
=======================================

// Module: paralelo_serie_param
// PURPOSE
//   Parametrised parallel-to-serial converter. It shifts WIDTH-bit words out on one
//   serial line, one bit per clk_8f cycle, with no gaps between words.
//   An input FIFO of DEPTH words with a ready handshake absorbs bursts.
//   When the FIFO is empty, the block sends IDLE_WORD as link filler (default 8'hBC).
//   Successor to the fixed 8-bit/clk_f+clk_8f converter. This block uses a single
//   bit clock and generates the word boundary internally.
// PARAMETERS
//   WIDTH      8      word width in bits; must be >= 2
//   DEPTH      4      FIFO depth in words; power of 2, >= 2
//   IDLE_WORD  8'hBC  filler word sent when the FIFO is empty; WIDTH bits wide
//   MSB_FIRST  1      1: serialise bit WIDTH-1 first; 0: serialise bit 0 first
// PORTS
//   clk_8f      in   1                bit clock; the only clock
//   reset       in   1                synchronous, active-high
//   valid_in    in   1                data_inP holds a word to enqueue
//   data_inP    in   WIDTH            parallel input word
//   ready_out   out  1                FIFO can accept a word (count < DEPTH)
//   data_outS   out  1                serial output bit, registered
//   data2send   out  WIDTH            word currently being serialised, registered
//   word_start  out  1                1-cycle pulse, aligned with the first bit of each word
//   idle_out    out  1                current word is IDLE_WORD filler, not FIFO data
//   fifo_count  out  $clog2(DEPTH)+1  words held in the FIFO
//   overflow    out  1                sticky: a word was dropped (valid_in while !ready_out)
// BEHAVIOUR
//   Reset, sampled on the clk_8f edge:
//     data_outS=0, data2send=0, word_start=0, idle_out=0, overflow=0.
//     FIFO emptied (fifo_count=0), bit_cnt=0, state=INIT.
//   FSM states: INIT and SHIFT.
//     INIT (first cycle after reset deasserts): perform a LOAD, then go to SHIFT.
//     SHIFT: if bit_cnt < WIDTH, drive the next bit and bit_cnt++.
//            if bit_cnt == WIDTH, perform a LOAD.
//   LOAD edge actions:
//     W = FIFO head if fifo_count>0 (pop it), else IDLE_WORD.
//     data2send<=W; data_outS<=first bit of W; bit_cnt<=1; word_start<=1;
//     idle_out<=(FIFO was empty).
//   Bit order: bit index i = bit_cnt for MSB_FIRST=0; WIDTH-1-bit_cnt for MSB_FIRST=1.
//   Each word occupies exactly WIDTH consecutive data_outS cycles.
//   word_start period is exactly WIDTH cycles; it is never back-to-back.
//   Write: on an edge with valid_in && ready_out, push data_inP.
//   ready_out is combinational from the fifo_count register only.
//     It does not depend on a same-edge pop.
//   Drop: valid_in && !ready_out. The word is discarded and overflow<=1.
//     overflow clears only on reset.
//   Write and pop on the same edge:
//     Both occur; fifo_count is unchanged.
//     No bypass: a word written into an empty FIFO is not popped on that same edge.
//     IDLE_WORD goes out on that edge instead.
//   Latency: from the write edge to the first serial bit of the word is
//     1..WIDTH cycles, plus WIDTH cycles for each word already queued.
//   Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH or goes below 0.
//   Reset mid-word aborts the word immediately. Queued data is lost.
//     The next word after reset is IDLE_WORD.
// TESTING
//   (default params unless noted)
//   1 Hold reset 3 cycles -> all outputs 0. Release -> word_start every 8 cycles,
//     data2send=8'hBC, data_outS=1,0,1,1,1,1,0,0, idle_out=1.
//   2 Single write 8'hA5 mid-idle -> next LOAD: data2send=8'hA5, serial 10100101,
//     idle_out=0 for that word, then back to 8'hBC.
//   3 Write 6 words 11,22,33,44,55,66 on the 6 cycles right after a LOAD
//     -> first 4 accepted, ready_out=0 at fifo_count=4, 55 and 66 dropped,
//     overflow=1. Serial stream: 11,22,33,44,BC.
//   4 MSB_FIRST=0 with write 8'h01 -> serial 1,0,0,0,0,0,0,0.
//     Then BC LSB-first: 0,0,1,1,1,1,0,1.
//   5 Reset at bit_cnt=4 with fifo_count=2 and overflow=1 -> next cycle all outputs 0,
//     fifo_count=0, overflow=0. After release, BC resumes with a fresh word_start.
//   6 WIDTH=10, IDLE_WORD=10'h17C, DEPTH=8 -> word_start period 10. Fill 8 words
//     while draining -> same-edge push/pop keeps fifo_count steady; no data loss.

Source files
------------

// File: rtl/paralelo_serie_param_if.sv
// Parallel-to-serial link bundle: write handshake on one side, serial stream and
// status flags on the other.
interface paralelo_serie_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    logic                     valid_in;
    logic [WIDTH-1:0]         data_inP;
    logic                     ready_out;
    logic                     data_outS;
    logic [WIDTH-1:0]         data2send;
    logic                     word_start;
    logic                     idle_out;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     overflow;

    // Word producer side
    modport master (
        output valid_in,
        output data_inP,
        input  ready_out,
        input  data_outS,
        input  data2send,
        input  word_start,
        input  idle_out,
        input  fifo_count,
        input  overflow
    );

    // Converter side
    modport slave (
        input  valid_in,
        input  data_inP,
        output ready_out,
        output data_outS,
        output data2send,
        output word_start,
        output idle_out,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/paralelo_serie_param.sv
// Parallel-to-serial converter: WIDTH-bit words from a DEPTH-entry FIFO are shifted
// out one bit per clk_8f cycle with no gaps; IDLE_WORD fills the line when empty.
module paralelo_serie_param #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC),
    parameter bit               MSB_FIRST = 1'b1
) (
    input logic                  clk_8f,
    input logic                  reset,
    paralelo_serie_param_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned FcW  = PtrW + 1;

    localparam logic [CntW-1:0] BitCntLast = CntW'(WIDTH);
    localparam logic [FcW-1:0]  FifoFull   = FcW'(DEPTH);

    typedef enum logic {StInit, StShift} state_e;

    state_e           r_state;
    state_e           w_state_next;

    logic [CntW-1:0]  r_bit_cnt;
    logic [WIDTH-1:0] r_data2send;
    logic             r_data_outS;
    logic             r_word_start;
    logic             r_idle;
    logic             r_overflow;
    logic [FcW-1:0]   r_fifo_count;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_load;
    logic             w_fifo_empty;
    logic             w_ready;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic [WIDTH-1:0] w_word;
    logic             w_first_bit;
    logic [IdxW-1:0]  w_bit_idx;
    logic             w_shift_bit;
    logic [FcW-1:0]   w_fifo_count_next;

    // State register
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_state <= StInit;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: INIT lasts exactly one cycle, SHIFT runs forever
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StInit:  w_state_next = StShift;
            StShift: w_state_next = StShift;
            default: w_state_next = StInit;
        endcase
    end

    // Output decode: a word is loaded on the INIT cycle and after its last bit
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            StInit:  w_load = 1'b1;
            StShift: w_load = (r_bit_cnt == BitCntLast);
            default: w_load = 1'b0;
        endcase
    end

    // ready_out looks only at the registered count, never at a same-edge pop
    assign w_fifo_empty      = (r_fifo_count == '0);
    assign w_ready           = (r_fifo_count < FifoFull);
    assign w_push            = bus.valid_in && w_ready;
    assign w_drop            = bus.valid_in && !w_ready;
    assign w_pop             = w_load && !w_fifo_empty;
    assign w_fifo_count_next = r_fifo_count + FcW'(w_push) - FcW'(w_pop);

    // Head is read from storage only; a same-edge write cannot bypass into the load
    assign w_word      = w_fifo_empty ? IDLE_WORD : r_mem[r_rd_ptr];
    assign w_first_bit = MSB_FIRST ? w_word[WIDTH-1] : w_word[0];
    assign w_bit_idx   = MSB_FIRST ? IdxW'(WIDTH - 1 - 32'(r_bit_cnt)) : IdxW'(r_bit_cnt);
    assign w_shift_bit = r_data2send[w_bit_idx];

    // FIFO storage write
    always_ff @(posedge clk_8f) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= bus.data_inP;
        end
    end

    // FIFO pointers, count, overflow flag and serialiser datapath
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            r_overflow   <= 1'b0;
            r_bit_cnt    <= '0;
            r_data2send  <= '0;
            r_data_outS  <= 1'b0;
            r_word_start <= 1'b0;
            r_idle       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_fifo_count <= w_fifo_count_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_load) begin
                r_data2send  <= w_word;
                r_data_outS  <= w_first_bit;
                r_bit_cnt    <= CntW'(1);
                r_word_start <= 1'b1;
                r_idle       <= w_fifo_empty;
            end else begin
                r_data_outS  <= w_shift_bit;
                r_bit_cnt    <= r_bit_cnt + CntW'(1);
                r_word_start <= 1'b0;
            end
        end
    end

    assign bus.ready_out  = w_ready;
    assign bus.data_outS  = r_data_outS;
    assign bus.data2send  = r_data2send;
    assign bus.word_start = r_word_start;
    assign bus.idle_out   = r_idle;
    assign bus.fifo_count = r_fifo_count;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_paralelo_serie_param.sv
// Directed bench for paralelo_serie_param: default MSB-first instance, an LSB-first
// instance and a 10-bit/8-deep instance share clock and reset.
module tb_paralelo_serie_param;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] d2s;
        logic        idle;
    } rec_t;

    typedef struct packed {
        logic [7:0]  cnt;
        logic [15:0] sh;
        logic        idle;
        logic [15:0] d2s;
        logic        push;
        logic        gap;
    } mon_t;

    logic clk_8f = 1'b0;
    logic reset  = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int gap0 = 0;
    int gap1 = 0;
    int gap2 = 0;

    rec_t q0[$];
    rec_t q1[$];
    rec_t q2[$];
    mon_t m0 = '0;
    mon_t m1 = '0;
    mon_t m2 = '0;

    paralelo_serie_param_if #(.WIDTH(8),  .DEPTH(4)) bus0 ();
    paralelo_serie_param_if #(.WIDTH(8),  .DEPTH(4)) bus1 ();
    paralelo_serie_param_if #(.WIDTH(10), .DEPTH(8)) bus2 ();

    paralelo_serie_param #(
        .WIDTH(8), .DEPTH(4), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1)
    ) u_dut0 (
        .clk_8f(clk_8f), .reset(reset), .bus(bus0)
    );

    paralelo_serie_param #(
        .WIDTH(8), .DEPTH(4), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b0)
    ) u_dut1 (
        .clk_8f(clk_8f), .reset(reset), .bus(bus1)
    );

    paralelo_serie_param #(
        .WIDTH(10), .DEPTH(8), .IDLE_WORD(10'h17C), .MSB_FIRST(1'b1)
    ) u_dut2 (
        .clk_8f(clk_8f), .reset(reset), .bus(bus2)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Assembles serial words and flags any word_start spacing other than w cycles
    function automatic mon_t mon_step(input mon_t m, input int w, input bit msb,
                                      input logic rst, input logic ws, input logic b,
                                      input logic idle, input logic [15:0] d2s);
        mon_t n = m;
        n.push = 1'b0;
        n.gap  = 1'b0;
        if (rst) begin
            n.cnt = '0;
        end else if (ws) begin
            if (m.cnt != 0 && 32'(m.cnt) != w) n.gap = 1'b1;
            n.cnt  = 8'd1;
            n.idle = idle;
            n.d2s  = d2s;
            n.sh   = msb ? 16'(b) : (16'(b) << (w - 1));
        end else if (32'(m.cnt) == w) begin
            n.gap = 1'b1;
            n.cnt = '0;
        end else if (m.cnt != 0) begin
            n.sh  = msb ? ((m.sh << 1) | 16'(b)) : ((m.sh >> 1) | (16'(b) << (w - 1)));
            n.cnt = m.cnt + 8'd1;
            if (32'(n.cnt) == w) n.push = 1'b1;
        end
        return n;
    endfunction

    always @(negedge clk_8f) begin
        m0 = mon_step(m0, 8, 1'b1, reset, bus0.word_start, bus0.data_outS, bus0.idle_out,
                      16'(bus0.data2send));
        if (m0.push) q0.push_back('{word: m0.sh, d2s: m0.d2s, idle: m0.idle});
        if (m0.gap) gap0++;
        m1 = mon_step(m1, 8, 1'b0, reset, bus1.word_start, bus1.data_outS, bus1.idle_out,
                      16'(bus1.data2send));
        if (m1.push) q1.push_back('{word: m1.sh, d2s: m1.d2s, idle: m1.idle});
        if (m1.gap) gap1++;
        m2 = mon_step(m2, 10, 1'b1, reset, bus2.word_start, bus2.data_outS, bus2.idle_out,
                      16'(bus2.data2send));
        if (m2.push) q2.push_back('{word: m2.sh, d2s: m2.d2s, idle: m2.idle});
        if (m2.gap) gap2++;
    end

    task automatic tick();
        @(posedge clk_8f);
        #1;
    endtask

    // Advance to the sample just after a word_start, then drop older captured words
    task automatic sync_ws(input int which);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            case (which)
                0:       found = bus0.word_start;
                1:       found = bus1.word_start;
                default: found = bus2.word_start;
            endcase
        end
        check_eq("sync_ws", 32'(found), 32'd1);
        case (which)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic expect_rec(input int which, input string tag, input logic [15:0] exp_word,
                              input logic exp_idle);
        logic found = 1'b0;
        rec_t r = '0;
        for (int i = 0; i < 60 && !found; i++) begin
            case (which)
                0:       if (q0.size() > 0) begin r = q0.pop_front(); found = 1'b1; end
                1:       if (q1.size() > 0) begin r = q1.pop_front(); found = 1'b1; end
                default: if (q2.size() > 0) begin r = q2.pop_front(); found = 1'b1; end
            endcase
            if (!found) tick();
        end
        check_eq({tag, "_avail"}, 32'(found), 32'd1);
        if (found) begin
            check_eq({tag, "_serial"}, 32'(r.word), 32'(exp_word));
            check_eq({tag, "_data2send"}, 32'(r.d2s), 32'(exp_word));
            check_eq({tag, "_idle"}, 32'(r.idle), 32'(exp_idle));
        end
    endtask

    task automatic check_zero0(input string tag);
        check_eq({tag, "_data_outS"}, 32'(bus0.data_outS), 32'd0);
        check_eq({tag, "_data2send"}, 32'(bus0.data2send), 32'd0);
        check_eq({tag, "_word_start"}, 32'(bus0.word_start), 32'd0);
        check_eq({tag, "_idle_out"}, 32'(bus0.idle_out), 32'd0);
        check_eq({tag, "_fifo_count"}, 32'(bus0.fifo_count), 32'd0);
        check_eq({tag, "_overflow"}, 32'(bus0.overflow), 32'd0);
        check_eq({tag, "_ready"}, 32'(bus0.ready_out), 32'd1);
    endtask

    logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [9:0] w6 [8] = '{10'h201, 10'h102, 10'h3FF, 10'h000,
                           10'h155, 10'h2AA, 10'h0F0, 10'h30F};

    initial begin
        bus0.valid_in = 1'b0; bus0.data_inP = '0;
        bus1.valid_in = 1'b0; bus1.data_inP = '0;
        bus2.valid_in = 1'b0; bus2.data_inP = '0;

        // Reset held, then idle filler
        reset = 1'b1;
        repeat (3) tick();
        check_zero0("rst");
        reset = 1'b0;
        tick();
        check_eq("first_ws", 32'(bus0.word_start), 32'd1);
        check_eq("first_d2s", 32'(bus0.data2send), 32'hBC);
        check_eq("first_idle", 32'(bus0.idle_out), 32'd1);
        check_eq("first_bit", 32'(bus0.data_outS), 32'd1);
        q0.delete();
        expect_rec(0, "idle_a", 16'h00BC, 1'b1);
        expect_rec(0, "idle_b", 16'h00BC, 1'b1);

        // Single write landing on a load edge: no bypass, goes out one word later
        sync_ws(0);
        repeat (7) tick();
        bus0.valid_in = 1'b1; bus0.data_inP = 8'hA5;
        tick();
        bus0.valid_in = 1'b0;
        check_eq("nobyp_ws", 32'(bus0.word_start), 32'd1);
        check_eq("nobyp_d2s", 32'(bus0.data2send), 32'hBC);
        check_eq("nobyp_idle", 32'(bus0.idle_out), 32'd1);
        check_eq("nobyp_cnt", 32'(bus0.fifo_count), 32'd1);
        repeat (8) tick();
        check_eq("a5_ws", 32'(bus0.word_start), 32'd1);
        check_eq("a5_d2s", 32'(bus0.data2send), 32'hA5);
        check_eq("a5_idle", 32'(bus0.idle_out), 32'd0);
        check_eq("a5_cnt", 32'(bus0.fifo_count), 32'd0);
        expect_rec(0, "t2_w0", 16'h00BC, 1'b1);
        expect_rec(0, "t2_w1", 16'h00BC, 1'b1);
        expect_rec(0, "t2_w2", 16'h00A5, 1'b0);
        expect_rec(0, "t2_w3", 16'h00BC, 1'b1);

        // Burst of six: four accepted, two dropped
        sync_ws(0);
        for (int i = 0; i < 6; i++) begin
            bus0.valid_in = 1'b1; bus0.data_inP = burst[i];
            if (i == 0) check_eq("burst_ready0", 32'(bus0.ready_out), 32'd1);
            if (i == 4) begin
                check_eq("burst_ready4", 32'(bus0.ready_out), 32'd0);
                check_eq("burst_cnt4", 32'(bus0.fifo_count), 32'd4);
            end
            tick();
        end
        bus0.valid_in = 1'b0;
        check_eq("burst_ovf", 32'(bus0.overflow), 32'd1);
        check_eq("burst_cnt", 32'(bus0.fifo_count), 32'd4);
        expect_rec(0, "t3_w0", 16'h00BC, 1'b1);
        expect_rec(0, "t3_w1", 16'h0011, 1'b0);
        expect_rec(0, "t3_w2", 16'h0022, 1'b0);
        expect_rec(0, "t3_w3", 16'h0033, 1'b0);
        expect_rec(0, "t3_w4", 16'h0044, 1'b0);
        expect_rec(0, "t3_w5", 16'h00BC, 1'b1);

        // Reset mid-word with queued data and overflow set
        sync_ws(0);
        bus0.valid_in = 1'b1; bus0.data_inP = 8'h77;
        tick();
        bus0.data_inP = 8'h88;
        tick();
        bus0.valid_in = 1'b0;
        tick();
        check_eq("pre_rst_cnt", 32'(bus0.fifo_count), 32'd2);
        check_eq("pre_rst_ovf", 32'(bus0.overflow), 32'd1);
        reset = 1'b1;
        tick();
        check_zero0("midrst");
        reset = 1'b0;
        q0.delete();
        tick();
        check_eq("post_rst_ws", 32'(bus0.word_start), 32'd1);
        check_eq("post_rst_d2s", 32'(bus0.data2send), 32'hBC);
        check_eq("post_rst_idle", 32'(bus0.idle_out), 32'd1);
        expect_rec(0, "t5_w0", 16'h00BC, 1'b1);
        expect_rec(0, "t5_w1", 16'h00BC, 1'b1);

        // LSB-first instance
        sync_ws(1);
        bus1.valid_in = 1'b1; bus1.data_inP = 8'h01;
        tick();
        bus1.valid_in = 1'b0;
        expect_rec(1, "t4_w0", 16'h00BC, 1'b1);
        expect_rec(1, "t4_w1", 16'h0001, 1'b0);
        expect_rec(1, "t4_w2", 16'h00BC, 1'b1);

        // 10-bit instance: writes on load edges keep the count steady
        sync_ws(2);
        bus2.valid_in = 1'b1; bus2.data_inP = w6[0];
        tick();
        bus2.valid_in = 1'b0;
        check_eq("t6_cnt0", 32'(bus2.fifo_count), 32'd1);
        repeat (8) tick();
        for (int k = 1; k < 8; k++) begin
            bus2.valid_in = 1'b1; bus2.data_inP = w6[k];
            tick();
            bus2.valid_in = 1'b0;
            check_eq("t6_ws", 32'(bus2.word_start), 32'd1);
            check_eq("t6_cnt", 32'(bus2.fifo_count), 32'd1);
            repeat (9) tick();
        end
        expect_rec(2, "t6_idle0", 16'h017C, 1'b1);
        for (int k = 0; k < 8; k++) begin
            expect_rec(2, "t6_data", 16'(w6[k]), 1'b0);
        end
        expect_rec(2, "t6_idle1", 16'h017C, 1'b1);
        check_eq("t6_ovf", 32'(bus2.overflow), 32'd0);
        check_eq("t4_ovf", 32'(bus1.overflow), 32'd0);

        check_eq("gap0", 32'(gap0), 32'd0);
        check_eq("gap1", 32'(gap1), 32'd0);
        check_eq("gap2", 32'(gap2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
